fast_score_unit: RTL and testbench
==================================

# fast_score_unit

Upstream producer for the non-maximum-suppression stage. It scans a stored grey-scale image in raster order and runs the FAST-9 segment test on every pixel. For each pixel it writes one 8-bit corner score into score memory. The NMS stage later reads that memory through its own score address/data port. Border pixels, which lack a full radius-3 circle, get a score of 0.

## Interface
Parameters:
- WIDTH, 180: image width in pixels; must be ≥ 7.
- HEIGHT, 180: image height in pixels; must be ≥ 7. WIDTH*HEIGHT ≤ 32768.

Ports:
- clock  input  1  single clock, all state on rising edge
- nReset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a full-image pass when idle
- threshold  input  8  FAST threshold t, sampled on accepted start
- pixAddr  output  15  image memory read address
- pixData  input  8  image memory read data, valid 1 cycle after pixAddr (synchronous RAM)
- scoreAddr  output  15  score memory write address (= current reference pixel address)
- scoreData  output  8  score to write
- scoreWe  output  1  score memory write enable
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse after the last score write

## Operation
- Address mapping: addr = y*WIDTH + x. The scan runs x fastest, from addr 0 to WIDTH*HEIGHT-1.
- Circle index k = 0..15 has these (dx,dy) offsets: (0,-3) (1,-3) (2,-2) (3,-1) (3,0) (3,1) (2,2) (1,3) (0,3) (-1,3) (-2,2) (-3,1) (-3,0) (-3,-1) (-2,-2) (-1,-3).
  - Fetch address = ref + dy*WIDTH + dx, computed without wrap.
- Interior pixel: 3 ≤ x ≤ WIDTH-4 and 3 ≤ y ≤ HEIGHT-4. Every other pixel is border.
- FSM states: IDLE, BORDER, FETCH, LAST, EVAL, WRITE, DONE.
  - IDLE: when start=1, latch threshold, set ref=0 and go to BORDER or FETCH according to the classification of pixel 0. A start pulse while not in IDLE is ignored.
  - BORDER (1 cycle): scoreWe=1 and scoreData=0. Advance ref.
  - FETCH (17 cycles, j=0..16): pixAddr = center for j=0, and circle k=j-1 for j ≥ 1. The data for issue j-1 is captured each cycle: issue 0 goes to the center register c, issue k+1 goes to p[k].
  - LAST (1 cycle): capture p[15].
  - EVAL (1 cycle): compute the score and register it.
  - WRITE (1 cycle): scoreWe=1 with the registered score. Advance ref.
  - Advance rule: if ref was the last pixel, go to DONE. Otherwise classify ref+1 and enter BORDER or FETCH.
  - DONE (1 cycle): done=1, then go to IDLE.
- Score arithmetic uses at least 9-bit operands, so nothing overflows.
  - A circle pixel is bright when p > c + t, and dark when p + t < c. Both comparisons are strict.
  - Corner: 9 or more contiguous bright pixels, or 9 or more contiguous dark pixels, on the circle, with index 15 wrapping to index 0.
  - sB = Σ over bright pixels of (p − c − t). sD = Σ over dark pixels of (c − p − t). Both sums are 12 bits.
  - score = corner ? min(255, max(sB, sD)) : 0.
- pixAddr holds its last value when not in FETCH. Its value is don't-care when unused, but it must always be in range.

## Timing
- Reset values: pixAddr=0, scoreAddr=0, scoreData=0, scoreWe=0, busy=0, done=0. The FSM goes to IDLE and internal registers clear.
- Reset asserted mid-pass aborts immediately. No further writes occur, and a new start is required.
- Cycle counts:
  - Interior pixel: 20 cycles from entering FETCH to the WRITE cycle inclusive.
  - Border pixel: 1 cycle.
  - Full pass: 20·(W−6)(H−6) + (W·H − (W−6)(H−6)) cycles, then 1 DONE cycle.
- scoreAddr, scoreData and scoreWe are registered and valid in the same cycle. Exactly one write occurs per pixel, in ascending address order.
- busy falls in the same cycle that done is high.

## Test plan
- Uniform image: WIDTH=HEIGHT=8, all pixels 50, t=20, start.
  - Expect 64 writes, all data 0, in addresses 0..63 in order.
  - done arrives 141 cycles after the start cycle (140 pass + DONE), and busy is high throughout.
- Dark centre: 8×8 image, all 50, pixel (3,3)=10, t=20.
  - addr 27 → 255 (sB=320, saturated).
  - addr 28, 35, 36 → 0.
- Exact arc: centre (3,3)=100, circle k=0..8 = 140, other circle pixels = 100, t=20.
  - addr 27 → 180.
  - Repeat with k=0..7 only → addr 27 = 0.
  - Repeat with the original arc but 120 (= c+t) → addr 27 = 0.
- Wrap-around arc: circle k=12..15 and k=0..4 dark (= 60), centre 100, t=20. Expect addr 27 → 180.
- Control: a start pulse during the pass is ignored and the write count stays 64. Asserting nReset at cycle 50 gives an immediate return to reset values and no further scoreWe. A new start then completes a normal pass.

Source files
------------

// File: rtl/fast_score_unit_if.sv
// fast_score_unit_if: control, image-read and score-write signals of the FAST scorer.
// The slave side is the scorer; the master side is whoever owns the memories and start.
interface fast_score_unit_if;
   logic        start;
   logic [7:0]  threshold;
   logic [14:0] pixAddr;
   logic [7:0]  pixData;
   logic [14:0] scoreAddr;
   logic [7:0]  scoreData;
   logic        scoreWe;
   logic        busy;
   logic        done;
   modport master (
      output start, threshold, pixData,
      input  pixAddr, scoreAddr, scoreData, scoreWe, busy, done
   );
   modport slave (
      input  start, threshold, pixData,
      output pixAddr, scoreAddr, scoreData, scoreWe, busy, done
   );
endinterface

// File: rtl/fast_score_unit.sv
// fast_score_unit: raster-scans a stored image, runs the FAST-9 segment test on every
// pixel and writes one 8-bit corner score per pixel (border pixels score 0).
module fast_score_unit #(
   parameter int WIDTH  = 180,
   parameter int HEIGHT = 180
) (
   input logic clock,
   input logic nReset,
   fast_score_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, BORDER, FETCH, LAST, EVAL, WRITE, DONE} state_t;
   localparam logic [14:0] XMAX  = 15'(WIDTH - 1);
   localparam logic [14:0] XHI   = 15'(WIDTH - 4);
   localparam logic [14:0] YHI   = 15'(HEIGHT - 4);
   localparam logic [14:0] LASTA = 15'(WIDTH * HEIGHT - 1);
   localparam int OFFS [16] = '{
      -3*WIDTH, -3*WIDTH+1, -2*WIDTH+2, -WIDTH+3, 3, WIDTH+3, 2*WIDTH+2, 3*WIDTH+1,
      3*WIDTH, 3*WIDTH-1, 2*WIDTH-2, WIDTH-3, -3, -WIDTH-3, -2*WIDTH-2, -3*WIDTH-1
   };
   state_t state;
   logic [14:0] refAddr, x, y, nx, ny;
   logic [4:0] j;
   logic [7:0] thr, c, score;
   logic [7:0] p [16];
   logic [15:0] bright, dark;
   logic [11:0] sB, sD, sMax;
   logic corner, nInt;

   function automatic logic arc9(input logic [15:0] m);
      logic [31:0] d;
      d = {m, m};
      arc9 = 1'b0;
      for (int i = 0; i < 16; i++) arc9 |= &d[i +: 9];
   endfunction

   always_comb begin
      nx = (x == XMAX) ? '0 : x + 15'd1;
      ny = (x == XMAX) ? y + 15'd1 : y;
      nInt = nx >= 15'd3 && nx <= XHI && ny >= 15'd3 && ny <= YHI;
   end

   always_comb begin
      bright = '0;
      dark = '0;
      sB = '0;
      sD = '0;
      for (int k = 0; k < 16; k++) begin
         bright[k] = {1'b0, p[k]} > {1'b0, c} + {1'b0, thr};
         dark[k] = {1'b0, p[k]} + {1'b0, thr} < {1'b0, c};
         if (bright[k]) sB = sB + {4'b0, p[k]} - {4'b0, c} - {4'b0, thr};
         if (dark[k]) sD = sD + {4'b0, c} - {4'b0, p[k]} - {4'b0, thr};
      end
      corner = arc9(bright) || arc9(dark);
      sMax = (sB > sD) ? sB : sD;
      score = !corner ? 8'd0 : (sMax > 12'd255) ? 8'hFF : sMax[7:0];
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         refAddr <= '0;
         x <= '0;
         y <= '0;
         j <= '0;
         thr <= '0;
         c <= '0;
         for (int k = 0; k < 16; k++) p[k] <= '0;
         bus.pixAddr <= '0;
         bus.scoreAddr <= '0;
         bus.scoreData <= '0;
         bus.scoreWe <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.scoreWe <= 1'b0;
         bus.done <= 1'b0;
         case (state)
            // pixel 0 has x=0, so it is always a border pixel
            IDLE: if (bus.start) begin
               thr <= bus.threshold;
               refAddr <= '0;
               x <= '0;
               y <= '0;
               bus.busy <= 1'b1;
               bus.scoreWe <= 1'b1;
               bus.scoreData <= '0;
               bus.scoreAddr <= '0;
               state <= BORDER;
            end
            // issue j is presented now; the data arriving is issue j-1
            FETCH: begin
               if (j == 5'd1) c <= bus.pixData;
               else if (j != 5'd0) p[4'(j - 5'd2)] <= bus.pixData;
               if (j == 5'd16) state <= LAST;
               else bus.pixAddr <= 15'(int'(refAddr) + OFFS[j[3:0]]);
               j <= j + 5'd1;
            end
            LAST: begin
               p[15] <= bus.pixData;
               state <= EVAL;
            end
            EVAL: begin
               bus.scoreWe <= 1'b1;
               bus.scoreData <= score;
               bus.scoreAddr <= refAddr;
               state <= WRITE;
            end
            BORDER, WRITE: if (refAddr == LASTA) begin
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state <= DONE;
            end else begin
               refAddr <= refAddr + 15'd1;
               x <= nx;
               y <= ny;
               j <= '0;
               if (nInt) begin
                  bus.pixAddr <= refAddr + 15'd1;
                  state <= FETCH;
               end else begin
                  bus.scoreWe <= 1'b1;
                  bus.scoreData <= '0;
                  bus.scoreAddr <= refAddr + 15'd1;
                  state <= BORDER;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fast_score_unit.sv
// tb_fast_score_unit: table-driven and randomized checks of fast_score_unit on an 8x8
// image against a plain-arithmetic FAST-9 reference model.
module tb_fast_score_unit;
   localparam int W = 8, H = 8, N = W * H;
   localparam int DXT [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
   localparam int DYT [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
   typedef struct {int ctr; int bg; logic [15:0] mask; int arc; int t; int exp27;} vec_t;

   logic clock = 1'b0;
   logic nReset = 1'b0;
   fast_score_unit_if bus();
   fast_score_unit #(.WIDTH(W), .HEIGHT(H)) dut (.clock(clock), .nReset(nReset), .bus(bus));
   always #5 clock = ~clock;

   logic [7:0] img [N];
   int scoreMem [N];
   int wrAddr [$];
   int checks = 0;
   int errors = 0;

   always @(posedge clock) bus.pixData <= img[int'(bus.pixAddr) % N];
   always @(negedge clock) if (bus.scoreWe) begin
      wrAddr.push_back(int'(bus.scoreAddr));
      scoreMem[int'(bus.scoreAddr) % N] = int'(bus.scoreData);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model(input int a, input int t);
      int x = a % W, y = a / W, c, p, sb = 0, sd = 0, runB = 0, runD = 0, bestB = 0, bestD = 0, m;
      if (x < 3 || x > W - 4 || y < 3 || y > H - 4) return 0;
      c = int'(img[a]);
      for (int i = 0; i < 32; i++) begin
         p = int'(img[(y + DYT[i % 16]) * W + x + DXT[i % 16]]);
         runB = (p > c + t) ? runB + 1 : 0;
         runD = (p + t < c) ? runD + 1 : 0;
         if (runB > bestB) bestB = runB;
         if (runD > bestD) bestD = runD;
         if (i < 16 && p > c + t) sb += p - c - t;
         if (i < 16 && p + t < c) sd += c - p - t;
      end
      if (bestB < 9 && bestD < 9) return 0;
      m = (sb > sd) ? sb : sd;
      return (m > 255) ? 255 : m;
   endfunction

   task automatic checkReset(input string tag);
      check({tag, "_pixAddr"}, int'(bus.pixAddr), 0);
      check({tag, "_scoreAddr"}, int'(bus.scoreAddr), 0);
      check({tag, "_scoreData"}, int'(bus.scoreData), 0);
      check({tag, "_scoreWe"}, int'(bus.scoreWe), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
   endtask

   // call at a negedge; counts cycles after the start edge until done (or resetAt)
   task automatic runPass(input int t, input int pokeAt, input int resetAt,
                          output int cycles, output int busyBad);
      wrAddr.delete();
      for (int i = 0; i < N; i++) scoreMem[i] = -1;
      busyBad = 0;
      cycles = 0;
      bus.threshold = 8'(t);
      bus.start = 1'b1;
      do begin
         @(negedge clock);
         cycles++;
         bus.start = (cycles == pokeAt);
         if (cycles == resetAt) return;
         if (bus.done) begin
            if (bus.busy) busyBad++;
            break;
         end
         if (!bus.busy) busyBad++;
      end while (cycles < 2000);
   endtask

   task automatic checkPass(input string tag, input int t, input int cycles, input int busyBad);
      int ord = 0, bad = 0;
      check({tag, "_cycles"}, cycles, 141);
      check({tag, "_busy"}, busyBad, 0);
      check({tag, "_writes"}, wrAddr.size(), N);
      for (int i = 0; i < wrAddr.size(); i++) if (wrAddr[i] != i) ord++;
      check({tag, "_order"}, ord, 0);
      for (int a = 0; a < N; a++) if (scoreMem[a] != model(a, t)) bad++;
      check({tag, "_model"}, bad, 0);
   endtask

   vec_t vecs [6];
   int cyc, bb, n0, t, s, len, br, a, v;
   int centres [2] = '{27, 36};

   initial begin
      vecs[0] = '{50, 50, 16'h0000, 0, 20, 0};
      vecs[1] = '{10, 50, 16'h0000, 0, 20, 255};
      vecs[2] = '{100, 100, 16'h01FF, 140, 20, 180};
      vecs[3] = '{100, 100, 16'h00FF, 140, 20, 0};
      vecs[4] = '{100, 100, 16'h01FF, 120, 20, 0};
      vecs[5] = '{100, 100, 16'hF01F, 60, 20, 180};
      bus.start = 1'b0;
      bus.threshold = '0;
      for (int i = 0; i < N; i++) img[i] = '0;
      repeat (3) @(negedge clock);
      checkReset("reset");
      nReset = 1'b1;
      repeat (2) @(negedge clock);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) img[i] = 8'(vecs[r].bg);
         img[27] = 8'(vecs[r].ctr);
         for (int k = 0; k < 16; k++)
            if (vecs[r].mask[k]) img[(3 + DYT[k]) * W + 3 + DXT[k]] = 8'(vecs[r].arc);
         runPass(vecs[r].t, -1, -1, cyc, bb);
         checkPass($sformatf("vec%0d", r), vecs[r].t, cyc, bb);
         check($sformatf("vec%0d_addr27", r), scoreMem[27], vecs[r].exp27);
         check($sformatf("vec%0d_addr28", r), scoreMem[28], 0);
         check($sformatf("vec%0d_addr35", r), scoreMem[35], 0);
         check($sformatf("vec%0d_addr36", r), scoreMem[36], 0);
         @(negedge clock);
      end

      for (int r = 0; r < 8; r++) begin
         t = $urandom_range(5, 30);
         for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(80, 120));
         for (int ci = 0; ci < 2; ci++) begin
            a = centres[ci];
            s = $urandom_range(0, 15);
            len = $urandom_range(7, 12);
            br = $urandom_range(0, 1);
            for (int k = 0; k < len; k++) begin
               v = br ? int'(img[a]) + t + $urandom_range(0, 40) : int'(img[a]) - t - $urandom_range(0, 40);
               img[a + DYT[(s + k) % 16] * W + DXT[(s + k) % 16]] = 8'(v);
            end
         end
         runPass(t, -1, -1, cyc, bb);
         checkPass($sformatf("rand%0d", r), t, cyc, bb);
         @(negedge clock);
      end

      runPass(20, 30, -1, cyc, bb);
      checkPass("poke", 20, cyc, bb);
      @(negedge clock);

      runPass(20, -1, 50, cyc, bb);
      nReset = 1'b0;
      #1;
      checkReset("abort");
      n0 = wrAddr.size();
      check("abort_writes_before", n0, 28);
      repeat (4) @(negedge clock);
      nReset = 1'b1;
      repeat (40) @(negedge clock);
      check("abort_nowrite", wrAddr.size(), n0);
      check("abort_idle_busy", int'(bus.busy), 0);

      runPass(20, -1, -1, cyc, bb);
      checkPass("restart", 20, cyc, bb);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
